// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: valid/ready handshake with a two-entry skid buffer,
// synchronous flush, and instruction field decode taken from the main entry.
module if_id_pipe_reg #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter bit          IMM_SEXT  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc4,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_func,
  output logic [15:0]     out_imm,
  output logic [31:0]     out_imm_ext,
  output logic [25:0]     out_addr,
  output logic [PC_W-1:0] out_pc4
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t            state_r, state_s;
  logic [31:0]     main_instr_r, main_instr_s;
  logic [PC_W-1:0] main_pc4_r, main_pc4_s;
  logic [31:0]     skid_instr_r, skid_instr_s;
  logic [PC_W-1:0] skid_pc4_r, skid_pc4_s;
  logic            accept_s;
  logic            pop_s;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm);
    if (IMM_SEXT) begin
      extend_imm = {{16{imm[15]}}, imm};
    end else begin
      extend_imm = {16'h0000, imm};
    end
  endfunction

  // Handshake is derived only from registered occupancy, never from out_ready.
  assign in_ready  = (state_r != FULL);
  assign out_valid = (state_r != EMPTY);
  assign accept_s  = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  assign out_opcode  = main_instr_r[31:26];
  assign out_rs      = main_instr_r[25:21];
  assign out_rt      = main_instr_r[20:16];
  assign out_rd      = main_instr_r[15:11];
  assign out_shamt   = main_instr_r[10:6];
  assign out_func    = main_instr_r[5:0];
  assign out_imm     = main_instr_r[15:0];
  assign out_imm_ext = extend_imm(main_instr_r[15:0]);
  assign out_addr    = main_instr_r[25:0];
  assign out_pc4     = main_pc4_r;

  // Next occupancy and entry contents; flush overrides every transition.
  always_comb begin
    state_s      = state_r;
    main_instr_s = main_instr_r;
    main_pc4_s   = main_pc4_r;
    skid_instr_s = skid_instr_r;
    skid_pc4_s   = skid_pc4_r;
    if (flush) begin
      state_s      = EMPTY;
      main_instr_s = NOP_INSTR;
      main_pc4_s   = {PC_W{1'b0}};
      skid_instr_s = NOP_INSTR;
      skid_pc4_s   = {PC_W{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_s      = ONE;
            main_instr_s = in_instr;
            main_pc4_s   = in_pc4;
          end else begin
            state_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            main_instr_s = in_instr;
            main_pc4_s   = in_pc4;
          end else if (accept_s) begin
            state_s      = FULL;
            skid_instr_s = in_instr;
            skid_pc4_s   = in_pc4;
          end else if (pop_s) begin
            state_s = EMPTY;
          end else begin
            state_s = ONE;
          end
        end
        FULL: begin
          // The skid entry is older than anything fetch can offer, so it drains first.
          if (pop_s) begin
            state_s      = ONE;
            main_instr_s = skid_instr_r;
            main_pc4_s   = skid_pc4_r;
          end else begin
            state_s = FULL;
          end
        end
        default: begin
          state_s      = EMPTY;
          main_instr_s = NOP_INSTR;
          main_pc4_s   = {PC_W{1'b0}};
        end
      endcase
    end
  end

  // State and entry registers with asynchronous reset to an empty NOP-filled stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= EMPTY;
      main_instr_r <= NOP_INSTR;
      main_pc4_r   <= {PC_W{1'b0}};
      skid_instr_r <= NOP_INSTR;
      skid_pc4_r   <= {PC_W{1'b0}};
    end else begin
      state_r      <= state_s;
      main_instr_r <= main_instr_s;
      main_pc4_r   <= main_pc4_s;
      skid_instr_r <= skid_instr_s;
      skid_pc4_r   <= skid_pc4_s;
    end
  end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: directed scenarios plus randomized traffic scored
// against a queue model of a two-deep in-order buffer.
module tb_if_id_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode, out_func;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm;
  logic [31:0] out_imm_ext;
  logic [25:0] out_addr;
  logic [31:0] out_pc4;

  logic        z_in_ready, z_out_valid;
  logic [5:0]  z_opcode, z_func;
  logic [4:0]  z_rs, z_rt, z_rd, z_shamt;
  logic [15:0] z_imm;
  logic [31:0] z_imm_ext;
  logic [25:0] z_addr;
  logic [31:0] z_pc4;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] q[$];  // {instr, pc4}, oldest first

  if_id_pipe_reg #(.PC_W(32), .NOP_INSTR(32'h0000_0000), .IMM_SEXT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc4(in_pc4), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_func(out_func), .out_imm(out_imm),
    .out_imm_ext(out_imm_ext), .out_addr(out_addr), .out_pc4(out_pc4)
  );

  if_id_pipe_reg #(.PC_W(32), .NOP_INSTR(32'h0000_0000), .IMM_SEXT(1'b0)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_instr(in_instr), .in_pc4(in_pc4), .flush(flush),
    .out_valid(z_out_valid), .out_ready(out_ready),
    .out_opcode(z_opcode), .out_rs(z_rs), .out_rt(z_rt), .out_rd(z_rd),
    .out_shamt(z_shamt), .out_func(z_func), .out_imm(z_imm),
    .out_imm_ext(z_imm_ext), .out_addr(z_addr), .out_pc4(z_pc4)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext16(input logic [15:0] v);
    if (v >= 16'h8000) sext16 = 32'(v) - 32'h0001_0000;
    else sext16 = 32'(v);
  endfunction

  task automatic compare_model();
    logic [63:0] e;
    check_eq("valid", out_valid, q.size() > 0);
    check_eq("in_ready", in_ready, q.size() < 2);
    check_eq("z_valid", z_out_valid, q.size() > 0);
    if (q.size() > 0) begin
      e = q[0];
      check_eq("instr", {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_func}, e[63:32]);
      check_eq("pc4", out_pc4, e[31:0]);
      check_eq("addr", out_addr, e[57:32]);
      check_eq("imm", out_imm, e[47:32]);
      check_eq("imm_sext", out_imm_ext, sext16(e[47:32]));
      check_eq("imm_zext", z_imm_ext, 32'(e[47:32]));
    end
  endtask

  task automatic step();
    bit acc, pop;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    pop = (q.size() > 0) && out_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({in_instr, in_pc4});
    end
    @(negedge clk);
    compare_model();
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic r, input logic f);
    in_valid = v; in_instr = i; in_pc4 = p; out_ready = r; flush = f;
  endtask

  initial begin
    logic [31:0] pc;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_ready", in_ready, 1'b1);
    check_eq("rst_pc4", out_pc4, 32'h0);
    check_eq("rst_opcode", out_opcode, 6'h0);
    rst_n = 1'b1;

    // Streaming with decode always ready.
    drive(1'b1, 32'h012A_4020, 32'h4, 1'b1, 1'b0);
    step();
    check_eq("add_valid", out_valid, 1'b1);
    check_eq("add_opcode", out_opcode, 6'd0);
    check_eq("add_rs", out_rs, 5'd9);
    check_eq("add_rt", out_rt, 5'd10);
    check_eq("add_rd", out_rd, 5'd8);
    check_eq("add_shamt", out_shamt, 5'd0);
    check_eq("add_func", out_func, 6'h20);
    check_eq("add_pc4", out_pc4, 32'h4);
    check_eq("add_ready", in_ready, 1'b1);
    drive(1'b1, 32'h2128_FFFC, 32'h8, 1'b1, 1'b0);
    step();
    check_eq("addi_imm", out_imm, 16'hFFFC);
    check_eq("addi_sext", out_imm_ext, 32'hFFFF_FFFC);
    check_eq("addi_zext", z_imm_ext, 32'h0000_FFFC);
    drive(1'b1, 32'h0800_0010, 32'hC, 1'b1, 1'b0);
    step();
    check_eq("j_addr", out_addr, 26'h000_0010);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();

    // Stall: A then B fill the stage, C waits at fetch.
    drive(1'b1, 32'hAAAA_0001, 32'h4, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hBBBB_0002, 32'h8, 1'b0, 1'b0);
    step();
    check_eq("stall_ready", in_ready, 1'b0);
    check_eq("stall_pc4", out_pc4, 32'h4);
    drive(1'b1, 32'hCCCC_0003, 32'hC, 1'b0, 1'b0);
    step();
    check_eq("stall_hold_pc4", out_pc4, 32'h4);
    drive(1'b1, 32'hCCCC_0003, 32'hC, 1'b1, 1'b0);
    step();
    check_eq("skid_pc4", out_pc4, 32'h8);
    check_eq("skid_ready", in_ready, 1'b1);
    step();
    check_eq("c_pc4", out_pc4, 32'hC);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();

    // Flush while full with D offered.
    drive(1'b1, 32'h1111_0004, 32'h10, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h2222_0005, 32'h14, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hDDDD_DDDD, 32'h18, 1'b0, 1'b1);
    step();
    check_eq("flush_valid", out_valid, 1'b0);
    check_eq("flush_ready", in_ready, 1'b1);
    check_eq("flush_opcode", out_opcode, 6'h0);
    check_eq("flush_func", out_func, 6'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check_eq("flush_no_d", out_valid, 1'b0);

    // Asynchronous reset between edges while full.
    drive(1'b1, 32'h3333_0006, 32'h1C, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h4444_0007, 32'h20, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 1'b0);
    check_eq("arst_ready", in_ready, 1'b1);
    check_eq("arst_pc4", out_pc4, 32'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    compare_model();

    // Randomized traffic against the queue model.
    pc = 32'h100;
    for (int i = 0; i < 10000; i++) begin
      pc = pc + 32'd4;
      drive($urandom_range(0, 3) != 0, $urandom, pc,
            $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
